// File: rtl/alu_param.sv
// Handshaked ALU with IDLE/BUSY/DONE control and registered result, result_hi and flags.
// Define ALU_PARAM_MUL_EN to build the WIDTH-cycle shift-add multiplier for op 111.
module alu_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  localparam logic [WIDTH:0] SHIFT_LIMIT = WIDTH[WIDTH:0];

  state_t state_q, state_d;
  logic   accept;
  logic   is_mul;
  logic   mul_last;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle operations
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (op_t'(op_select))
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // carry_out = 1 means no borrow
        alu_res   = sub_sum[WIDTH-1:0];
        alu_carry = sub_sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = ({1'b0, b} >= SHIFT_LIMIT) ? '0 : (a << b);
      OP_SHR: alu_res = ({1'b0, b} >= SHIFT_LIMIT) ? '0 : (a >> b);
      default: begin
`ifdef ALU_PARAM_MUL_EN
        alu_res = '0;
`else
        alu_ill = 1'b1;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier datapath: one multiplier bit consumed per BUSY cycle
  // ---------------------------------------------------------------------------
`ifdef ALU_PARAM_MUL_EN
  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  assign is_mul   = (op_select == OP_MUL);
  assign mul_last = (cnt_q == CNT_LAST);
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: these working registers are reloaded on every accepted MUL, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = is_mul ? S_BUSY : S_DONE;
      S_BUSY:  if (mul_last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Result and flag registers; rst clears them so an aborted result never shows
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      result    <= alu_res;
      result_hi <= '0;
      carry_out <= alu_carry;
      overflow  <= alu_ovf;
      zero      <= (alu_res == '0);
      illegal   <= alu_ill;
    end
`ifdef ALU_PARAM_MUL_EN
    else if ((state_q == S_BUSY) && mul_last) begin
      result    <= acc_next[WIDTH-1:0];
      result_hi <= acc_next[2*WIDTH-1:WIDTH];
      carry_out <= 1'b0;
      overflow  <= (acc_next[2*WIDTH-1:WIDTH] != '0);
      zero      <= (acc_next == '0);
      illegal   <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_param.sv
// Randomized self-checking bench for alu_param (WIDTH=4) against an arithmetic reference model.
// Define ALU_PARAM_MUL_EN for both bench and RTL to exercise the multiplier build.
module tb_alu_param;

  localparam int W = 4;
  localparam int M = 1 << W;
`ifdef ALU_PARAM_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    int res;
    int hi;
    bit c;
    bit v;
    bit z;
    bit ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op_select;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_select (op_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Signed interpretation of a W-bit value
  function automatic int sgn(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic exp_t model(input int x, input int y, input int op);
    exp_t e;
    int   s;
    int   p;
    e = '{default: 0};
    case (op)
      0: begin
        s     = x + y;
        e.res = s % M;
        e.c   = (s >= M);
        e.v   = (sgn(x) + sgn(y) > M / 2 - 1) || (sgn(x) + sgn(y) < -M / 2);
      end
      1: begin
        s     = x + (M - 1 - y) + 1;
        e.res = s % M;
        e.c   = (s >= M);
        e.v   = (sgn(x) - sgn(y) > M / 2 - 1) || (sgn(x) - sgn(y) < -M / 2);
      end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: e.res = (y >= W) ? 0 : (x * (1 << y)) % M;
      6: e.res = (y >= W) ? 0 : x / (1 << y);
      default: begin
        if (MUL_EN) begin
          p     = x * y;
          e.res = p % M;
          e.hi  = p / M;
          e.v   = (e.hi != 0);
        end else begin
          e.ill = 1'b1;
        end
      end
    endcase
    e.z = (e.res == 0) && (e.hi == 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction: accept, latency check with ignored in_valid noise, hold, release
  task automatic do_op(input int x, input int y, input int op, input int hold);
    exp_t e;
    int   lat;
    e   = model(x, y, op);
    lat = (MUL_EN && op == 7) ? W : 1;
    check("idle_in_ready", in_ready, 1);
    a         = W'(x);
    b         = W'(y);
    op_select = 3'(op);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    a         = W'($urandom_range(0, M - 1));
    b         = W'($urandom_range(0, M - 1));
    op_select = 3'($urandom_range(0, 7));
    for (int n = 1; n < lat; n++) begin
      check("busy_out_valid", out_valid, 0);
      check("busy_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    for (int h = 0; h <= hold; h++) begin
      check("done_out_valid", out_valid, 1);
      check("done_in_ready", in_ready, 0);
      check("result", result, e.res);
      check("result_hi", result_hi, e.hi);
      check("carry_out", carry_out, e.c);
      check("overflow", overflow, e.v);
      check("zero", zero, e.z);
      check("illegal", illegal, e.ill);
      if (h == hold) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end else begin
        in_valid  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_result"}, result, 0);
    check({tag, "_result_hi"}, result_hi, 0);
    check({tag, "_flags"}, {carry_out, overflow, zero, illegal}, 0);
  endtask

  // Reset mid-operation: the pending result must never be presented
  task automatic abort_test(input int x, input int y, input int op);
    int wait_n;
    wait_n    = (MUL_EN && op == 7) ? 2 : 1;
    a         = W'(x);
    b         = W'(y);
    op_select = 3'(op);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    for (int n = 1; n < wait_n; n++) tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_cleared("abort");
    for (int n = 0; n < 2 * W; n++) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op_select = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    tick();

    do_op(3, 5, 0, 0);
    do_op(9, 8, 0, 0);
    do_op(7, 3, 1, 0);
    do_op(3, 7, 1, 0);
    do_op(5, 5, 1, 0);
    do_op(3, 5, 0, 5);
    do_op(15, 15, 7, 1);
    do_op(0, 9, 7, 0);
    do_op(5, 4, 5, 0);
    do_op(9, 1, 6, 0);
    do_op(3, 15, 5, 0);
    do_op(12, 10, 2, 0);
    do_op(12, 10, 3, 0);
    do_op(12, 10, 4, 0);

    abort_test(15, 15, 7);
    abort_test(3, 5, 0);

    // Reset wins over a simultaneous accept in IDLE
    a         = W'(3);
    b         = W'(5);
    op_select = 3'd0;
    in_valid  = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    check_cleared("rst_prio");
    tick();
    check("rst_prio_no_valid", out_valid, 0);

    for (int i = 0; i < 300; i++) begin
      do_op($urandom_range(0, M - 1), $urandom_range(0, M - 1),
            $urandom_range(0, 7), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 SHALL have ports a, b  input  WIDTH each  operands, sampled on accept edge only.
REQ-007 SHALL have port op_select  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 SHALL have port out_valid  output  1  result registers hold a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports result  output  WIDTH  low result word; result_hi  output  WIDTH  MUL upper word, 0 for all other ops.
REQ-011 SHALL have ports carry_out, overflow, zero, illegal  output  1 each  status flags, registered with result.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; accept = in_valid & in_ready on a rising edge.
REQ-013 Non-MUL ops SHALL go IDLE->DONE on accept edge; out_valid high in the following cycle (latency 1).
REQ-014 MUL SHALL go IDLE->BUSY on accept, run an unsigned shift-add, one multiplier bit per cycle, reaching DONE exactly WIDTH cycles after the accept edge.
REQ-015 DONE SHALL hold result, result_hi and flags stable while out_ready=0; DONE->IDLE on the edge where out_ready=1.
REQ-016 in_valid during BUSY or DONE SHALL be ignored (in_ready=0); no request queued.
REQ-017 ADD: result = (a+b) mod 2^WIDTH, carry_out = bit WIDTH of the sum, overflow = signed two's-complement overflow.
REQ-018 SUB: computed as a + ~b + 1; carry_out = carry of that sum (1 = no borrow, 0 = borrow); overflow = signed overflow of a-b.
REQ-019 AND/OR/XOR: bitwise; carry_out=0, overflow=0.
REQ-020 SHL/SHR: logical shift of a by unsigned b; b >= WIDTH gives result 0; carry_out=0, overflow=0.
REQ-021 MUL: {result_hi,result} = a*b unsigned, 2*WIDTH bits; carry_out=0; overflow = (result_hi != 0).
REQ-022 zero SHALL be 1 iff result (and result_hi for MUL) is all-zero.
REQ-023 illegal SHALL be 0 except as given in REQ-028.

Reset
REQ-024 rst=1 on an edge SHALL force IDLE, in_ready=1 in the next cycle, out_valid=0, result=0, result_hi=0, all flags 0.
REQ-025 rst during BUSY or DONE SHALL abort the operation; the pending result SHALL never appear on out_valid.
REQ-026 rst SHALL take priority over simultaneous accept or out_ready.

Configuration
REQ-027 Macro ALU_PARAM_MUL_EN defined: MUL implemented per REQ-014/REQ-021.
REQ-028 Macro ALU_PARAM_MUL_EN undefined: no multiplier/BUSY datapath; op 111 completes with latency 1, result=0, result_hi=0, zero=1, illegal=1, other flags 0.

Verification (WIDTH=4)
REQ-029 ADD a=3,b=5 -> one cycle later out_valid=1, result=8, carry_out=0, overflow=1, zero=0.
REQ-030 ADD a=9,b=8 -> result=1, carry_out=1, overflow=1; SUB a=7,b=3 -> result=4, carry_out=1, overflow=0.
REQ-031 SUB a=3,b=7 -> result=12, carry_out=0, overflow=0; SUB a=5,b=5 -> result=0, zero=1, carry_out=1.
REQ-032 MUL a=15,b=15 (MUL_EN defined) -> out_valid exactly 4 cycles after accept, result_hi=14, result=1, overflow=1; in_valid pulses during BUSY ignored.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after ADD 3+5 -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 Assert rst 2 cycles into MUL -> out_valid never rises for it, all outputs 0, in_ready=1 next cycle; without MUL_EN op 111 -> illegal=1, result=0.
